// File: rtl/boolean_expr_sweep_ctrl_pkg.sv
// Shared types and sizes for the boolean_expr truth-table sweep controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bool_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int NUM_VECTORS = 16;
    localparam int VEC_W       = 4;
    localparam int CNT_W       = 5;
    // 16 mismatches must be representable, hence one bit more than VEC_W
    localparam int MM_W        = 5;

endpackage

// File: rtl/boolean_expr_sweep_ctrl_if.sv
// Bundle between the sweep controller and its caller / boolean_expr instance.
// Latency: n/a (wires only).
// Backpressure: none; start is simply ignored while a sweep is running.
interface boolean_expr_sweep_ctrl_if;
    import bool_sweep_pkg::*;

    logic                   start;
    logic [NUM_VECTORS-1:0] expected;
    logic                   y;
    logic                   a;
    logic                   b;
    logic                   c;
    logic                   d;
    logic                   busy;
    logic                   done;
    logic [NUM_VECTORS-1:0] table_out;
    logic                   match;
    logic [MM_W-1:0]        mismatch_cnt;
    logic [VEC_W-1:0]       first_fail;
    logic                   first_fail_valid;

    // Caller / environment side: requests sweeps and supplies y
    modport master (
        output start, expected, y,
        input  a, b, c, d, busy, done, table_out, match,
               mismatch_cnt, first_fail, first_fail_valid
    );

    // Controller side
    modport slave (
        input  start, expected, y,
        output a, b, c, d, busy, done, table_out, match,
               mismatch_cnt, first_fail, first_fail_valid
    );

endinterface

// File: rtl/boolean_expr_sweep_ctrl.sv
// Steps {a,b,c,d} through all 16 vectors, samples y into a truth table, scores it vs expected.
// Latency: 16*(SETTLE+1) cycles from accepted start to the last capture; done one cycle later.
// Backpressure: start is only accepted in IDLE; requests during a sweep or DONE are dropped.
module boolean_expr_sweep_ctrl
    import bool_sweep_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    boolean_expr_sweep_ctrl_if.slave    bus
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
    localparam logic [VEC_W-1:0] LAST_IDX   = VEC_W'(NUM_VECTORS - 1);

    state_e                 state_q;
    logic [VEC_W-1:0]       idx_q;
    logic [VEC_W-1:0]       vec_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_VECTORS-1:0] exp_q;
    logic [NUM_VECTORS-1:0] table_q;
    logic                   match_q;
    logic                   busy_q;
    logic                   done_q;
    logic [MM_W-1:0]        mm_q;
    logic [VEC_W-1:0]       ff_q;
    logic                   ffv_q;

    logic                   miss_d;
    logic [MM_W-1:0]        mm_d;

    // Score of the sample being taken this cycle; mm_d includes it so match can be decided on entry to DONE
    always_comb begin
        miss_d = bus.y ^ exp_q[idx_q];
        mm_d   = mm_q + MM_W'(miss_d);
    end

    // Sweep sequencer with registered vector, status and result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            vec_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            table_q <= '0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mm_q    <= '0;
            ff_q    <= '0;
            ffv_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q <= WAIT;
                        idx_q   <= '0;
                        vec_q   <= '0;
                        cnt_q   <= CNT_RELOAD;
                        exp_q   <= bus.expected;
                        table_q <= '0;
                        match_q <= 1'b0;
                        mm_q    <= '0;
                        ff_q    <= '0;
                        ffv_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    table_q[idx_q] <= bus.y;
                    if (miss_d) begin
                        mm_q <= mm_d;
                        if (!ffv_q) begin
                            ff_q  <= idx_q;
                            ffv_q <= 1'b1;
                        end
                    end
                    // Terminal test keeps idx from wrapping 15 -> 0 inside a sweep
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        match_q <= (mm_d == '0);
                    end else begin
                        state_q <= WAIT;
                        idx_q   <= idx_q + VEC_W'(1);
                        vec_q   <= idx_q + VEC_W'(1);
                        cnt_q   <= CNT_RELOAD;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    vec_q   <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.a                = vec_q[3];
    assign bus.b                = vec_q[2];
    assign bus.c                = vec_q[1];
    assign bus.d                = vec_q[0];
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.table_out        = table_q;
    assign bus.match            = match_q;
    assign bus.mismatch_cnt     = mm_q;
    assign bus.first_fail       = ff_q;
    assign bus.first_fail_valid = ffv_q;

endmodule

// File: doc/boolean_expr_sweep_ctrl.md
# boolean_expr_sweep_ctrl

Sequencing controller for the 4-input `boolean_expr` datapath. On a start request it steps A,B,C,D through all 16 input combinations, waits a programmable settle time per vector, and samples Y into a 16-bit truth table. It compares that table against a caller-supplied expected mask and reports pass/fail, the mismatch count and the first failing index. It sits beside `boolean_expr` at the top level, drives its inputs and observes its output; it does not instantiate the expression itself.

## Interface
- `SETTLE`, default 1: cycles each vector is held before Y is sampled; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: sweep request; accepted only in IDLE.
- `expected` in 16: expected truth table, bit i = Y for vector i; latched on start acceptance.
- `y` in 1: output of `boolean_expr`.
- `a`, `b`, `c`, `d` out 1 each: vector to `boolean_expr`; {a,b,c,d} = idx, with a as the MSB.
- `busy` out 1: high in WAIT and SAMPLE.
- `done` out 1: one-cycle pulse, high in DONE.
- `table_out` out 16: captured truth table.
- `match` out 1: table_out == latched expected; valid from done onward.
- `mismatch_cnt` out 5: number of differing bits, 0..16.
- `first_fail` out 4: lowest failing index; valid when first_fail_valid is high.
- `first_fail_valid` out 1: at least one mismatch seen.

## Operation
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE, start high:
  - Set idx to 0 and cnt to SETTLE-1.
  - Latch expected.
  - Clear table_out, mismatch_cnt, first_fail, first_fail_valid and match.
  - Go to WAIT.
- WAIT: if cnt is 0, go to SAMPLE; otherwise decrement cnt. WAIT therefore lasts exactly SETTLE cycles.
- SAMPLE:
  - Write y into table_out[idx].
  - If y differs from exp_q[idx]: increment mismatch_cnt. If first_fail_valid is still 0, load first_fail with idx and set first_fail_valid.
  - If idx is 15, go to DONE. Otherwise increment idx, reload cnt with SETTLE-1 and go to WAIT.
- DONE:
  - done is high for this cycle.
  - match = (mismatch_cnt == 0), registered on the transition into DONE.
  - Then return to IDLE.
- Vector outputs:
  - {a,b,c,d} are driven from the idx register (glitch-free) during WAIT, SAMPLE and DONE.
  - In IDLE they return to 0.
- Results (table_out, match, mismatch_cnt, first_fail, first_fail_valid) hold their values until the next accepted start.
- start is ignored while busy or in DONE. A start held high through DONE is accepted on the first IDLE cycle after.
- idx does not wrap. The terminal test on 15 prevents idx going 15 -> 0 inside a sweep.

## Timing
- Reset values: state IDLE, idx 0, cnt 0, and all outputs 0: a..d, busy, done, table_out, match, mismatch_cnt, first_fail, first_fail_valid.
- Edge numbering: edge 0 is the rising edge at which start is sampled high in IDLE.
- busy is high from after edge 0.
- Vector n is presented from after edge n·(SETTLE+1).
- Vector n is captured at edge (n+1)·(SETTLE+1).
- The last capture is at edge 16·(SETTLE+1). done is high for the following cycle, and IDLE is re-entered one edge later.
- Sweep length: SETTLE=1 gives done after edge 32; SETTLE=3 gives done after edge 64.
- y is sampled at the SAMPLE edge only. It must be stable SETTLE cycles after the vector change.
- Reset mid-sweep: all registers go asynchronously to their reset values, and no done pulse is produced. After reset release the block stays in IDLE until start.
- mismatch_cnt is 5 bits wide so that 16 mismatches do not overflow.

## Structure
- Package `bool_sweep_pkg`:
  - state enum (IDLE, WAIT, SAMPLE, DONE)
  - `NUM_VECTORS` = 16
  - `VEC_W` = 4
  - `CNT_W` = 5
- Single flat module; no sub-module is needed.
- The settle counter and the mismatch tracker stay inline.
- The top level instantiates `boolean_expr_sweep_ctrl` and `boolean_expr` side by side.

## Test plan
- y = ~d, expected = 16'h5555, SETTLE=1 -> table_out = 16'h5555, match = 1, mismatch_cnt = 0, done pulses exactly once, one cycle wide, after edge 32.
- y = a & b, expected = 16'hF000, SETTLE=3 -> table_out = 16'hF000, match = 1, done after edge 64, and each vector is held for 4 cycles.
- y tied to 0, expected = 16'hFFFF -> table_out = 16'h0000, mismatch_cnt = 16, first_fail = 0, first_fail_valid = 1, match = 0.
- y = a & b, expected = 16'hF001 -> mismatch_cnt = 1, first_fail = 0, match = 0.
- Pulse start again at edges 5 and 20 while busy -> both ignored: a single sweep and a single done pulse. start held high through DONE -> a second sweep starts on the next IDLE cycle.
- Assert rst_n low at edge 10 of a sweep -> all outputs are 0 asynchronously with no done pulse. A later start runs a clean full sweep with correct results.
